ocp_arb2: RTL

- Two-master OCP arbiter that sits directly upstream of the behavioural memory (or any single OCP slave).
- Multiplexes an instruction-fetch master (m0) and a data master (m1) onto one slave port using round-robin grant.
- Routes read responses back to the issuing master.
- Guards against a hung slave with a response timeout that returns ERR.

---
 rtl/ocp_arb2_pkg.sv | 20 ++
 rtl/ocp_arb2_rr.sv | 25 ++
 rtl/ocp_arb2.sv | 133 +++++++++++++
 3 files changed

// File: rtl/ocp_arb2_pkg.sv
// Shared OCP command/response encodings and helpers for the two-master arbiter.
package ocp_arb2_pkg;

  localparam logic [2:0] OCP_CMD_IDLE  = 3'd0;
  localparam logic [2:0] OCP_CMD_WRITE = 3'd1;
  localparam logic [2:0] OCP_CMD_READ  = 3'd2;

  localparam logic [1:0] OCP_RESP_NULL = 2'd0;
  localparam logic [1:0] OCP_RESP_DVA  = 2'd1;
  localparam logic [1:0] OCP_RESP_FAIL = 2'd2;
  localparam logic [1:0] OCP_RESP_ERR  = 2'd3;

  localparam int NUM_MST = 2;

  // Only plain reads and writes are arbitrated; anything else is never granted.
  function automatic logic is_req(input logic [2:0] cmd);
    return (cmd == OCP_CMD_READ) || (cmd == OCP_CMD_WRITE);
  endfunction

endpackage

// File: rtl/ocp_arb2_rr.sv
// Two-way round-robin winner select with a registered last-grant pointer.
module ocp_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic       winner,
  output logic       any_req
);

  logic last;

  // On a tie the master that did not win last time goes first.
  always_comb begin
    any_req = |req;
    if (&req) winner = ~last;
    else      winner = req[1];
  end

  always_ff @(posedge clk) begin
    if (rst)                      last <= 1'b1;
    else if (grant_en && any_req) last <= winner;
  end

endmodule

// File: rtl/ocp_arb2.sv
// Two-master OCP arbiter: round-robin command grant, read response routing
// back to the issuing master, and an ERR response if the slave hangs.
module ocp_arb2
  import ocp_arb2_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int BEN_WIDTH    = 4,
  parameter int RESP_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] m0_MAddr,
  input  logic [2:0]            m0_MCmd,
  input  logic [DATA_WIDTH-1:0] m0_MData,
  input  logic [BEN_WIDTH-1:0]  m0_MByteEn,
  output logic                  m0_SCmdAccept,
  output logic [DATA_WIDTH-1:0] m0_SData,
  output logic [1:0]            m0_SResp,
  input  logic [ADDR_WIDTH-1:0] m1_MAddr,
  input  logic [2:0]            m1_MCmd,
  input  logic [DATA_WIDTH-1:0] m1_MData,
  input  logic [BEN_WIDTH-1:0]  m1_MByteEn,
  output logic                  m1_SCmdAccept,
  output logic [DATA_WIDTH-1:0] m1_SData,
  output logic [1:0]            m1_SResp,
  output logic [ADDR_WIDTH-1:0] s_MAddr,
  output logic [2:0]            s_MCmd,
  output logic [DATA_WIDTH-1:0] s_MData,
  output logic [BEN_WIDTH-1:0]  s_MByteEn,
  input  logic                  s_SCmdAccept,
  input  logic [DATA_WIDTH-1:0] s_SData,
  input  logic [1:0]            s_SResp
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CMD = 2'd1, S_RESP = 2'd2} state_t;

  localparam int CNT_W = $clog2(RESP_TIMEOUT);

  logic [NUM_MST-1:0][ADDR_WIDTH-1:0] m_addr;
  logic [NUM_MST-1:0][2:0]            m_cmd;
  logic [NUM_MST-1:0][DATA_WIDTH-1:0] m_data;
  logic [NUM_MST-1:0][BEN_WIDTH-1:0]  m_ben;
  logic [NUM_MST-1:0]                 req;
  logic [NUM_MST-1:0]                 acc;
  logic [NUM_MST-1:0][1:0]            resp;
  logic [NUM_MST-1:0][DATA_WIDTH-1:0] rdata;

  state_t           state, state_nxt;
  logic             owner;
  logic             winner, any_req;
  logic [CNT_W-1:0] cnt;
  logic             timeout;

  assign m_addr = {m1_MAddr, m0_MAddr};
  assign m_cmd  = {m1_MCmd, m0_MCmd};
  assign m_data = {m1_MData, m0_MData};
  assign m_ben  = {m1_MByteEn, m0_MByteEn};

  for (genvar i = 0; i < NUM_MST; i++) begin : g_req
    assign req[i] = is_req(m_cmd[i]);
  end

  ocp_rr_arb2 u_rr (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .grant_en (state == S_IDLE),
    .winner   (winner),
    .any_req  (any_req)
  );

  assign timeout = (cnt == CNT_W'(RESP_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      owner <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && any_req) owner <= winner;
      if (state == S_CMD)
        cnt <= '0;
      else if (state == S_RESP && s_SResp == OCP_RESP_NULL && !timeout)
        cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    s_MCmd    = OCP_CMD_IDLE;
    s_MAddr   = '0;
    s_MData   = '0;
    s_MByteEn = '0;
    acc       = '0;
    resp      = '0;
    rdata     = '0;
    case (state)
      S_IDLE: if (any_req) state_nxt = S_CMD;
      S_CMD: begin
        s_MCmd     = m_cmd[owner];
        s_MAddr    = m_addr[owner];
        s_MData    = m_data[owner];
        s_MByteEn  = m_ben[owner];
        acc[owner] = s_SCmdAccept;
        // Writes are posted: only a read waits for a response.
        if (s_SCmdAccept)
          state_nxt = (m_cmd[owner] == OCP_CMD_READ) ? S_RESP : S_IDLE;
      end
      S_RESP: begin
        resp[owner]  = s_SResp;
        rdata[owner] = s_SData;
        if (s_SResp != OCP_RESP_NULL) begin
          state_nxt = S_IDLE;
        end else if (timeout) begin
          resp[owner]  = OCP_RESP_ERR;
          rdata[owner] = '0;
          state_nxt    = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign m0_SCmdAccept = acc[0];
  assign m1_SCmdAccept = acc[1];
  assign m0_SResp      = resp[0];
  assign m1_SResp      = resp[1];
  assign m0_SData      = rdata[0];
  assign m1_SData      = rdata[1];

endmodule
